// File: rtl/bch_syndrome_calc.sv
// Bit-serial BCH syndrome calculator: Horner evaluation of S1..S2t over GF(2^m).
// Optional macro BCH_SYND_EVEN_SQR_EN: accumulate odd S_j only, derive S_2i = (S_i)^2 at output.
module bch_syndrome_calc #(
    parameter int unsigned m      = 7,
    parameter int unsigned t      = 10,
    parameter int unsigned n      = 127,
    parameter int unsigned irrpol = 137
) (
    input  logic                iclk,
    input  logic                ireset,
    input  logic                iclkena,
    input  logic                isop,
    input  logic                ieop,
    input  logic                ival,
    input  logic                idat,
    output logic                osyndrome_val,
    output logic [1:2*t][m-1:0] osyndrome,
    output logic                onzero,
    output logic                olen_err
);
    localparam int unsigned    T2     = 2 * t;
    localparam int unsigned    CW     = $clog2(n + 1);
    localparam logic [m-1:0]   Poly   = m'(irrpol);
    localparam logic [CW-1:0]  CntMax = '1;
    localparam logic [CW-1:0]  NLen   = CW'(n);

    typedef logic [1:2*t][m-1:0] synd_t;
    typedef enum logic {StIdle, StAcc} state_t;

    // Repeated multiply-by-alpha; p is a constant at every call site, so this folds to XORs.
    function automatic logic [m-1:0] mul_alpha_pow(input logic [m-1:0] a, input int unsigned p);
        logic [m-1:0] r;
        r = a;
        for (int unsigned k = 0; k < p; k++) begin
            r = {r[m-2:0], 1'b0} ^ (r[m-1] ? Poly : '0);
        end
        return r;
    endfunction

`ifdef BCH_SYND_EVEN_SQR_EN
    localparam bit EvenSqr = 1'b1;

    function automatic logic [m-1:0] gf_sqr(input logic [m-1:0] a);
        logic [m-1:0] r;
        r = '0;
        for (int k = m - 1; k >= 0; k--) begin
            r = mul_alpha_pow(r, 1) ^ (a[k] ? a : '0);
        end
        return r;
    endfunction

    // Ascending order lets S_4 = (S_2)^2 reuse the already-derived S_2.
    function automatic synd_t expand_even(input synd_t u);
        synd_t s;
        s = u;
        for (int unsigned j = 2; j <= T2; j += 2) begin
            s[j] = gf_sqr(s[j/2]);
        end
        return s;
    endfunction
`else
    localparam bit EvenSqr = 1'b0;
`endif

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_upd;
    synd_t         acc;
    synd_t         acc_upd;
    synd_t         syn_out;
    logic          accept;
    logic          fin;

    always_comb begin
        acc_upd = '0;
        for (int unsigned j = 1; j <= T2; j++) begin
            if (!(EvenSqr && (j % 2 == 0))) begin
                acc_upd[j] = isop ? {{(m-1){1'b0}}, idat}
                                  : (mul_alpha_pow(acc[j], j) ^ {{(m-1){1'b0}}, idat});
            end
        end
`ifdef BCH_SYND_EVEN_SQR_EN
        syn_out = expand_even(acc_upd);
`else
        syn_out = acc_upd;
`endif
        cnt_upd = isop ? CW'(1) : ((cnt == CntMax) ? cnt : cnt + CW'(1));
        accept  = ival && (isop || (state == StAcc));
        fin     = accept && ieop;
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            state         <= StIdle;
            cnt           <= '0;
            acc           <= '0;
            osyndrome_val <= 1'b0;
            osyndrome     <= '0;
            onzero        <= 1'b0;
            olen_err      <= 1'b0;
        end else if (iclkena) begin
            osyndrome_val <= fin;
            if (accept) begin
                acc   <= acc_upd;
                cnt   <= cnt_upd;
                state <= ieop ? StIdle : StAcc;
            end
            if (fin) begin
                osyndrome <= syn_out;
                onzero    <= |syn_out;
                olen_err  <= (cnt_upd != NLen);
            end
        end
    end

endmodule

// File: tb/tb_bch_syndrome_calc.sv
// Self-checking bench for bch_syndrome_calc (m=7, t=10, n=127) against a polynomial-evaluation model.
module tb_bch_syndrome_calc;
    localparam int T2 = 20;
    typedef logic [1:T2][6:0] synd_t;

    logic  iclk = 1'b0;
    logic  ireset, iclkena, isop, ieop, ival, idat;
    logic  osyndrome_val, onzero, olen_err;
    synd_t osyndrome;

    int tests_run    = 0;
    int tests_failed = 0;
    int strobe_cnt   = 0;

    bit         frame_q[$];
    logic [6:0] exp_t[127];
    synd_t      cap_syn[$];
    logic       cap_nz[$];
    logic       cap_le[$];

    bch_syndrome_calc dut (
        .iclk         (iclk),
        .ireset       (ireset),
        .iclkena      (iclkena),
        .isop         (isop),
        .ieop         (ieop),
        .ival         (ival),
        .idat         (idat),
        .osyndrome_val(osyndrome_val),
        .osyndrome    (osyndrome),
        .onzero       (onzero),
        .olen_err     (olen_err)
    );

    always #5 iclk = ~iclk;

    // A strobe is consumed on the enabled cycle it is seen in.
    always @(negedge iclk) begin
        if (ireset && iclkena && osyndrome_val) begin
            strobe_cnt++;
            cap_syn.push_back(osyndrome);
            cap_nz.push_back(onzero);
            cap_le.push_back(olen_err);
        end
    end

    // S_j = r(alpha^j), the first bit of the frame being the highest-degree coefficient.
    function automatic synd_t model_syn();
        synd_t s;
        int    len;
        len = frame_q.size();
        s   = '0;
        for (int j = 1; j <= T2; j++)
            for (int i = 0; i < len; i++)
                if (frame_q[i]) s[j] = s[j] ^ exp_t[(j * (len - 1 - i)) % 127];
        return s;
    endfunction

    function automatic logic model_len_err();
        int len;
        len = frame_q.size();
        if (len > 127) len = 127;
        return len != 127;
    endfunction

    task automatic fill_random(input int len);
        frame_q.delete();
        for (int i = 0; i < len; i++) frame_q.push_back(bit'($urandom_range(1, 0)));
    endtask

    task automatic drive_frame(input bit do_eop, input int gap_pct, input int stall_at);
        int len;
        len = frame_q.size();
        for (int i = 0; i < len; i++) begin
            while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
                ival = 1'b0;
                isop = 1'($urandom);
                ieop = 1'($urandom);
                idat = 1'($urandom);
                @(posedge iclk); #1;
            end
            ival = 1'b1;
            isop = (i == 0);
            ieop = do_eop && (i == len - 1);
            idat = frame_q[i];
            if (i == stall_at) begin
                iclkena = 1'b0;
                repeat (3) @(posedge iclk);
                #1 iclkena = 1'b1;
            end
            @(posedge iclk); #1;
        end
        ival = 1'b0; isop = 1'b0; ieop = 1'b0; idat = 1'b0;
    endtask

    task automatic await_strobe(input int target, output bit ok);
        for (int k = 0; k < 30 && strobe_cnt < target; k++) begin
            @(negedge iclk); #1;
        end
        ok = (strobe_cnt >= target);
    endtask

    task automatic pop_capture(output synd_t s, output logic nz, output logic le);
        if (cap_syn.size() > 0) begin
            s  = cap_syn.pop_front();
            nz = cap_nz.pop_front();
            le = cap_le.pop_front();
        end else begin
            s = 'x; nz = 1'bx; le = 1'bx;
        end
    endtask

    task automatic test_reset();
        ireset = 1'b0; iclkena = 1'b1; isop = 1'b0; ieop = 1'b0; ival = 1'b0; idat = 1'b0;
        repeat (3) @(posedge iclk);
        #1;
        tests_run++;
        if ({osyndrome_val, onzero, olen_err} !== 3'b000 || osyndrome !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: val/nz/le=%b syn=%h, need 000 and 0",
                     {osyndrome_val, onzero, olen_err}, osyndrome);
        end
        ireset = 1'b1;
        repeat (4) @(posedge iclk);
        #1;
        tests_run++;
        if (strobe_cnt !== 0 || osyndrome_val !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_no_strobe: strobes=%0d val=%b, need 0 and 0", strobe_cnt, osyndrome_val);
        end
    endtask

    // Drive one complete frame from frame_q and check the single resulting strobe.
    task automatic run_frame(input string name, input int gap_pct);
        synd_t es, gs;
        logic  gnz, gle;
        bit    ok;
        int    base;
        base = strobe_cnt;
        es   = model_syn();
        drive_frame(1'b1, gap_pct, -1);
        await_strobe(base + 1, ok);
        pop_capture(gs, gnz, gle);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL %s_strobe: strobes=%0d, need 1", name, strobe_cnt - base);
        end
        tests_run++;
        if (gs !== es) begin
            tests_failed++;
            $display("FAIL %s_syndrome: got %h, need %h", name, gs, es);
        end
        tests_run++;
        if (gnz !== (es != '0) || gle !== model_len_err()) begin
            tests_failed++;
            $display("FAIL %s_flags: nz/le=%b%b, need %b%b", name, gnz, gle, es != '0, model_len_err());
        end
    endtask

    task automatic test_fixed_frames();
        frame_q.delete();
        repeat (127) frame_q.push_back(1'b0);
        run_frame("zero_frame", 0);
        frame_q[126] = 1'b1;
        run_frame("last_bit", 0);
        tests_run++;
        if (osyndrome !== {T2{7'd1}}) begin
            tests_failed++;
            $display("FAIL last_bit_all_one: got %h, need all S_j=1", osyndrome);
        end
        frame_q[126] = 1'b0;
        frame_q[0]   = 1'b1;
        run_frame("first_bit", 0);
        tests_run++;
        if (osyndrome[1] !== 7'd68) begin
            tests_failed++;
            $display("FAIL first_bit_s1: got %0d, need 68", osyndrome[1]);
        end
    endtask

    task automatic test_one_bit();
        frame_q.delete();
        frame_q.push_back(1'b1);
        run_frame("one_bit", 0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            fill_random(127);
            run_frame("random", 20);
        end
        fill_random(100);
        run_frame("short_frame", 10);
    endtask

    task automatic test_back_to_back();
        synd_t e1, e2, gs;
        logic  gnz, gle;
        bit    ok;
        int    base;
        base = strobe_cnt;
        fill_random(127);
        e1 = model_syn();
        drive_frame(1'b1, 0, -1);
        fill_random(127);
        e2 = model_syn();
        drive_frame(1'b1, 0, -1);
        await_strobe(base + 2, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL b2b_strobes: got %0d, need 2", strobe_cnt - base);
        end
        pop_capture(gs, gnz, gle);
        tests_run++;
        if (gs !== e1) begin
            tests_failed++;
            $display("FAIL b2b_first: got %h, need %h", gs, e1);
        end
        pop_capture(gs, gnz, gle);
        tests_run++;
        if (gs !== e2 || gle !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_second: got %h le=%b, need %h le=0", gs, gle, e2);
        end
    endtask

    task automatic test_restart();
        int base;
        base = strobe_cnt;
        fill_random(50);
        drive_frame(1'b0, 0, -1);
        fill_random(127);
        run_frame("restart", 0);
        repeat (5) @(posedge iclk);
        #1;
        tests_run++;
        if (strobe_cnt !== base + 1) begin
            tests_failed++;
            $display("FAIL restart_single: strobes=%0d, need 1", strobe_cnt - base);
        end
    endtask

    task automatic test_clkena();
        synd_t es, gs;
        logic  gnz, gle;
        bit    ok;
        int    base;
        base = strobe_cnt;
        fill_random(127);
        es = model_syn();
        drive_frame(1'b1, 0, 40);
        iclkena = 1'b0;
        @(negedge iclk);
        tests_run++;
        if (osyndrome_val !== 1'b1 || strobe_cnt !== base) begin
            tests_failed++;
            $display("FAIL clkena_hold_val: val=%b strobes=%0d, need 1 and 0", osyndrome_val,
                     strobe_cnt - base);
        end
        repeat (2) @(posedge iclk);
        #1 iclkena = 1'b1;
        await_strobe(base + 1, ok);
        pop_capture(gs, gnz, gle);
        tests_run++;
        if (!ok || gs !== es || gle !== 1'b0) begin
            tests_failed++;
            $display("FAIL clkena_result: ok=%b got %h le=%b, need %h le=0", ok, gs, gle, es);
        end
        @(posedge iclk);
        @(negedge iclk);
        tests_run++;
        if (osyndrome_val !== 1'b0 || strobe_cnt !== base + 1) begin
            tests_failed++;
            $display("FAIL clkena_single: val=%b strobes=%0d, need 0 and 1", osyndrome_val,
                     strobe_cnt - base);
        end
    endtask

    task automatic test_mid_reset();
        int base;
        base = strobe_cnt;
        fill_random(60);
        drive_frame(1'b0, 0, -1);
        ireset  = 1'b0;
        iclkena = 1'b0;
        #3;
        tests_run++;
        if ({osyndrome_val, onzero, olen_err} !== 3'b000 || osyndrome !== '0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: val/nz/le=%b syn=%h, need 000 and 0",
                     {osyndrome_val, onzero, olen_err}, osyndrome);
        end
        repeat (2) @(posedge iclk);
        #1 ireset = 1'b1;
        iclkena = 1'b1;
        repeat (6) @(posedge iclk);
        #1;
        tests_run++;
        if (strobe_cnt !== base) begin
            tests_failed++;
            $display("FAIL midreset_no_strobe: strobes=%0d, need 0", strobe_cnt - base);
        end
        fill_random(127);
        run_frame("after_reset", 5);
    endtask

    initial begin
        logic [7:0] v;
        v = 8'd1;
        for (int i = 0; i < 127; i++) begin
            exp_t[i] = v[6:0];
            v = {v[6:0], 1'b0};
            if (v[7]) v = v ^ 8'd137;
        end
        test_reset();
        test_fixed_frames();
        test_one_bit();
        test_random();
        test_back_to_back();
        test_restart();
        test_clkena();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1);
    end

endmodule
